bus_req_arbiter: RTL

//  Round-robin arbiter for the shared SRAM/edge-PE task bus. Each packet engine
//  (PACKET_CNTL + decoder + RS cluster) raises Req and waits for grant.

---
 rtl/bus_req_arbiter_pkg.sv | 19 +
 rtl/bus_req_arbiter_rr_pick.sv | 40 ++++
 rtl/bus_req_arbiter.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/bus_req_arbiter_pkg.sv
// Shared types and sizing helpers for the task-bus request arbiter.
package bus_req_arbiter_pkg;

    localparam int NUM_EDGE_PE = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } arb_state_t;

    // Index width for n requesters; never narrower than one bit.
    function automatic int arb_id_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    localparam int ARB_ID_W = arb_id_w(NUM_EDGE_PE);

endpackage

// File: rtl/bus_req_arbiter_rr_pick.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
module bus_req_arbiter_rr_pick #(
    parameter int N    = 4,
    parameter int ID_W = 2
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic            found,
    output logic [ID_W-1:0] idx
);

    logic [N-1:0] rot;
    int           src;
    int           first;
    int           pos;

    always_comb begin
        rot   = '0;
        src   = 0;
        first = 0;
        pos   = 0;
        found = 1'b0;
        // rot[0] is the requester sitting at the pointer position
        for (int i = 0; i < N; i++) begin
            src = i + int'(ptr);
            if (src >= N) src = src - N;
            rot[i] = req[src];
        end
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                found = 1'b1;
                first = i;
            end
        end
        pos = first + int'(ptr);
        if (pos >= N) pos = pos - N;
        idx = ID_W'(pos);
    end

endmodule

// File: rtl/bus_req_arbiter.sv
// Round-robin owner arbiter for the shared SRAM / edge-PE task bus, with
// hold-time preemption and a programmable idle gap between owners.
module bus_req_arbiter
    import bus_req_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = NUM_EDGE_PE,
    parameter int MAX_HOLD   = 16,
    parameter int TURNAROUND = 1,
    localparam int ID_W      = arb_id_w(NUM_REQ)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    output logic               grant_valid,
    output logic [ID_W-1:0]    grant_id,
    output logic               preempt
);

    localparam int HOLD_W = $clog2(MAX_HOLD);

    arb_state_t         state_q, state_d;
    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [1:0]         gap_q, gap_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic               grant_valid_q, grant_valid_d;
    logic [ID_W-1:0]    grant_id_q, grant_id_d;
    logic               preempt_q, preempt_d;

    logic [ID_W-1:0]    owner_next;
    logic [ID_W-1:0]    pick_ptr;
    logic               pick_found;
    logic [ID_W-1:0]    pick_idx;
    logic               owner_req;
    logic               others_req;
    logic               hold_sat;
    logic               do_pick;

    // On a release the picker already looks from owner+1, so a zero-gap
    // handoff re-picks on the same edge.
    always_comb begin
        owner_next = (grant_id_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_id_q + ID_W'(1);
        pick_ptr   = (state_q == GRANT) ? owner_next : ptr_q;
        owner_req  = req[grant_id_q];
        others_req = |(req & ~grant_q);
        hold_sat   = (hold_q == HOLD_W'(MAX_HOLD - 1));
    end

    bus_req_arbiter_rr_pick #(
        .N    (NUM_REQ),
        .ID_W (ID_W)
    ) u_rr_pick (
        .req   (req),
        .ptr   (pick_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        hold_d     = hold_q;
        gap_d      = gap_q;
        grant_d    = grant_q;
        grant_id_d = grant_id_q;
        preempt_d  = 1'b0;
        do_pick    = 1'b0;

        case (state_q)
            IDLE: do_pick = 1'b1;
            GRANT: begin
                // Owner still requesting at a release means it was forced off
                if (!owner_req || (hold_sat && others_req)) begin
                    ptr_d     = owner_next;
                    preempt_d = owner_req;
                    grant_d   = '0;
                    if (TURNAROUND == 0) begin
                        do_pick = 1'b1;
                    end else begin
                        state_d = GAP;
                        gap_d   = 2'(TURNAROUND - 1);
                    end
                end else if (!hold_sat) begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            GAP: begin
                if (gap_q == 2'd0) do_pick = 1'b1;
                else gap_d = gap_q - 2'd1;
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase

        if (do_pick) begin
            grant_d = '0;
            if (pick_found) begin
                grant_d[pick_idx] = 1'b1;
                grant_id_d        = pick_idx;
                hold_d            = '0;
                state_d           = GRANT;
            end else begin
                state_d = IDLE;
            end
        end

        grant_valid_d = |grant_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            ptr_q         <= '0;
            hold_q        <= '0;
            gap_q         <= '0;
            grant_q       <= '0;
            grant_valid_q <= 1'b0;
            grant_id_q    <= '0;
            preempt_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            hold_q        <= hold_d;
            gap_q         <= gap_d;
            grant_q       <= grant_d;
            grant_valid_q <= grant_valid_d;
            grant_id_q    <= grant_id_d;
            preempt_q     <= preempt_d;
        end
    end

    assign grant       = grant_q;
    assign grant_valid = grant_valid_q;
    assign grant_id    = grant_id_q;
    assign preempt     = preempt_q;

endmodule
